// File: rtl/sobel_window_ctrl.sv
// Sobel front-end: two line buffers, a 3x3 shift window and a frame FSM with valid/ready on both sides.
// Optional SOBEL_WIN_COUNT_EN adds win_count_o, the number of windows handed off in the current frame.
module sobel_window_ctrl #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                                clk_i,
    input  logic                                nreset_i,
    input  logic                                frame_start_i,
    input  logic [PIXEL_WIDTH-1:0]              pix_data_i,
    input  logic                                pix_valid_i,
    output logic                                pix_ready_o,
    output logic [2:0][2:0][PIXEL_WIDTH-1:0]    matrix_pixels_o,
    output logic                                win_valid_o,
    input  logic                                win_ready_i,
    output logic                                busy_o,
`ifdef SOBEL_WIN_COUNT_EN
    output logic [$clog2((IMG_WIDTH-2)*(IMG_HEIGHT-2)+1)-1:0] win_count_o,
`endif
    output logic                                frame_done_o
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_FLUSH
    } state_t;

    typedef logic [2:0][2:0][PIXEL_WIDTH-1:0] win_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              win_valid_q, win_valid_d;
    logic              frame_done_q, frame_done_d;
    win_t              mat_q, mat_d;
    win_t              win_q, win_d;

    // Line buffers: line0 holds row r-2, line1 holds row r-1 at each column.
    logic [PIXEL_WIDTH-1:0] line0_mem [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] line1_mem [IMG_WIDTH];

    logic pix_acc;
    logic last_col;
    logic last_row;

    assign pix_ready_o     = ((state_q == S_PRIME) || (state_q == S_RUN))
                             && (!win_valid_q || win_ready_i);
    assign pix_acc         = pix_valid_i && pix_ready_o;
    assign last_col        = (col_q == COL_W'(IMG_WIDTH - 1));
    assign last_row        = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign matrix_pixels_o = mat_q;
    assign win_valid_o     = win_valid_q;
    assign busy_o          = (state_q != S_IDLE);
    assign frame_done_o    = frame_done_q;

    always_comb begin
        win_d        = win_q;
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        win_valid_d  = win_valid_q;
        mat_d        = mat_q;

        if (pix_acc) begin
            for (int v = 0; v < 3; v++) begin
                win_d[v][0] = win_q[v][1];
                win_d[v][1] = win_q[v][2];
            end
            win_d[0][2] = line0_mem[col_q];
            win_d[1][2] = line1_mem[col_q];
            win_d[2][2] = pix_data_i;
        end

        // A fresh window overrides the handoff clear, so consume+load needs no bubble.
        if (win_ready_i) begin
            win_valid_d = 1'b0;
        end
        if (pix_acc && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2))) begin
            win_valid_d = 1'b1;
            mat_d       = win_d;
        end

        if (pix_acc) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    state_d = S_PRIME;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_PRIME: begin
                if (pix_acc && last_col && (row_q == ROW_W'(1))) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pix_acc && last_col && last_row) begin
                    state_d = S_FLUSH;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_FLUSH: begin
                if (!win_valid_q || win_ready_i) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            mat_q        <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            mat_q        <= mat_d;
        end
    end

    // Pixel storage is never reset; stale contents are overwritten before use.
    always_ff @(posedge clk_i) begin
        win_q <= win_d;
        if (pix_acc) begin
            line0_mem[col_q] <= line1_mem[col_q];
            line1_mem[col_q] <= pix_data_i;
        end
    end

`ifdef SOBEL_WIN_COUNT_EN
    localparam int CNT_W = $clog2((IMG_WIDTH-2)*(IMG_HEIGHT-2)+1);
    logic [CNT_W-1:0] win_count_q, win_count_d;

    always_comb begin
        win_count_d = win_count_q;
        if ((state_q == S_IDLE) && frame_start_i) begin
            win_count_d = '0;
        end else if (win_valid_q && win_ready_i) begin
            win_count_d = win_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            win_count_q <= '0;
        end else begin
            win_count_q <= win_count_d;
        end
    end

    assign win_count_o = win_count_q;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on a 4x4 frame: image-level reference model plus directed frames.
module tb_sobel_window_ctrl;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int TOT = (W-2)*(H-2);

    typedef logic [2:0][2:0][7:0] mat_t;

    logic       clk = 1'b0;
    logic       nreset_i = 1'b0;
    logic       frame_start_i = 1'b0;
    logic [7:0] pix_data_i = '0;
    logic       pix_valid_i = 1'b0;
    logic       pix_ready_o;
    mat_t       matrix_pixels_o;
    logic       win_valid_o;
    logic       win_ready_i = 1'b1;
    logic       busy_o;
    logic       frame_done_o;
`ifdef SOBEL_WIN_COUNT_EN
    logic [$clog2(TOT+1)-1:0] win_count_o;
`endif

    always #5 clk = ~clk;

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8)) dut (
        .clk_i           (clk),
        .nreset_i        (nreset_i),
        .frame_start_i   (frame_start_i),
        .pix_data_i      (pix_data_i),
        .pix_valid_i     (pix_valid_i),
        .pix_ready_o     (pix_ready_o),
        .matrix_pixels_o (matrix_pixels_o),
        .win_valid_o     (win_valid_o),
        .win_ready_i     (win_ready_i),
        .busy_o          (busy_o),
`ifdef SOBEL_WIN_COUNT_EN
        .win_count_o     (win_count_o),
`endif
        .frame_done_o    (frame_done_o)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state after the next clock edge, derived from image coordinates.
    logic       chk_en     = 1'b0;
    logic       busy_m     = 1'b0;
    logic       accept_m   = 1'b0;
    logic       vld_m      = 1'b0;
    logic       done_m     = 1'b0;
    int         idx_m      = 0;
    int         win_cnt_m  = 0;
    mat_t       mat_m      = '0;
    logic [7:0] img [W*H];

    mat_t first_win, last_win;
    int   dut_hs     = 0;
    int   done_count = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_ready, acc, hs, busy_cur;
            int   r, c;
            exp_ready = accept_m && (!vld_m || win_ready_i);
            check("busy_o", 72'(busy_o), 72'(busy_m));
            check("pix_ready_o", 72'(pix_ready_o), 72'(exp_ready));
            check("win_valid_o", 72'(win_valid_o), 72'(vld_m));
            check("frame_done_o", 72'(frame_done_o), 72'(done_m));
            if (vld_m) check("matrix_pixels_o", matrix_pixels_o, mat_m);
`ifdef SOBEL_WIN_COUNT_EN
            check("win_count_o", 72'(win_count_o), 72'(win_cnt_m));
`endif
            if (win_valid_o && win_ready_i) begin
                if (dut_hs == 0) first_win = matrix_pixels_o;
                last_win = matrix_pixels_o;
                dut_hs++;
            end
            if (frame_done_o) done_count++;

            if (!nreset_i) begin
                busy_m = 0; accept_m = 0; vld_m = 0; done_m = 0;
                idx_m = 0; win_cnt_m = 0; mat_m = '0;
            end else begin
                busy_cur = busy_m;
                acc = accept_m && pix_valid_i && exp_ready;
                hs  = vld_m && win_ready_i;
                done_m = 1'b0;
                if (hs) begin
                    win_cnt_m++;
                    if (win_cnt_m == TOT) begin
                        done_m = 1'b1;
                        busy_m = 1'b0;
                    end
                end
                if (win_ready_i) vld_m = 1'b0;
                if (acc) begin
                    r = idx_m / W;
                    c = idx_m % W;
                    img[idx_m] = pix_data_i;
                    if (r >= 2 && c >= 2) begin
                        vld_m = 1'b1;
                        for (int v = 0; v < 3; v++)
                            for (int p = 0; p < 3; p++)
                                mat_m[v][p] = img[(r-2+v)*W + (c-2+p)];
                    end
                    idx_m++;
                    if (idx_m == W*H) begin
                        accept_m = 1'b0;
                        idx_m    = 0;
                    end
                end
                if (frame_start_i && !busy_cur) begin
                    busy_m = 1'b1; accept_m = 1'b1; idx_m = 0; win_cnt_m = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        logic acc;
        int   k;
        pix_data_i  = d;
        pix_valid_i = 1'b1;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 100) begin
            @(negedge clk);
            acc = pix_ready_o;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) check("pixel_accept_timeout", 72'(0), 72'(1));
        pix_valid_i = 1'b0;
    endtask

    task automatic start_frame();
        dut_hs = 0;
        frame_start_i = 1'b1;
        @(posedge clk);
        #1;
        frame_start_i = 1'b0;
        check("busy_after_start", 72'(busy_o), 72'(1));
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!frame_done_o && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("frame_done_seen", 72'(k < 40), 72'(1));
        check("idle_at_done", 72'(busy_o), 72'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input int lo, input int hi, input int base);
        for (int i = lo; i <= hi; i++) send(8'(base + i));
    endtask

    int d0;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 72'(busy_o), 72'(0));
        check("rst_win_valid", 72'(win_valid_o), 72'(0));
        check("rst_pix_ready", 72'(pix_ready_o), 72'(0));
        check("rst_frame_done", 72'(frame_done_o), 72'(0));
        check("rst_matrix", matrix_pixels_o, 72'(0));
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        nreset_i = 1'b1;

        // Pixels offered while idle must be refused.
        pix_data_i  = 8'd77;
        pix_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_pix_ready", 72'(pix_ready_o), 72'(0));
        check("idle_busy", 72'(busy_o), 72'(0));
        check("idle_win_valid", 72'(win_valid_o), 72'(0));
        pix_valid_i = 1'b0;

        // Frame 1: unstalled 0..15.
        d0 = done_count;
        start_frame();
        send_range(0, 15, 0);
        wait_done();
        check("f1_first", first_win, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
        check("f1_last", last_win, {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5});
        check("f1_windows", 72'(dut_hs), 72'(4));
        repeat (3) @(posedge clk);
        #1;
        check("f1_done_pulses", 72'(done_count - d0), 72'(1));
`ifdef SOBEL_WIN_COUNT_EN
        check("f1_win_count", 72'(win_count_o), 72'(4));
`endif

        // Frame 2: downstream stall of 5 cycles with the first window pending.
        d0 = done_count;
        start_frame();
`ifdef SOBEL_WIN_COUNT_EN
        check("f2_win_count_clr", 72'(win_count_o), 72'(0));
`endif
        send_range(0, 10, 0);
        win_ready_i = 1'b0;
        pix_data_i  = 8'd11;
        pix_valid_i = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_pix_ready", 72'(pix_ready_o), 72'(0));
            check("stall_matrix", matrix_pixels_o,
                  {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
        end
        win_ready_i = 1'b1;
        send_range(11, 15, 0);
        wait_done();
        check("f2_first", first_win, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
        check("f2_last", last_win, {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5});
        check("f2_windows", 72'(dut_hs), 72'(4));
        check("f2_done_pulses", 72'(done_count - d0), 72'(1));

        // Frame 3: reset after pixel 9, then a fresh frame.
        d0 = done_count;
        start_frame();
        send_range(0, 9, 0);
        nreset_i = 1'b0;
        @(posedge clk);
        #1;
        nreset_i = 1'b1;
        check("mid_rst_busy", 72'(busy_o), 72'(0));
        check("mid_rst_win_valid", 72'(win_valid_o), 72'(0));
        check("mid_rst_pix_ready", 72'(pix_ready_o), 72'(0));
        check("mid_rst_frame_done", 72'(frame_done_o), 72'(0));
        check("mid_rst_matrix", matrix_pixels_o, 72'(0));
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_done", 72'(done_count - d0), 72'(0));
        start_frame();
        send_range(0, 15, 100);
        wait_done();
        check("f3_first", first_win, {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100});
        check("f3_last", last_win, {8'd115, 8'd114, 8'd113, 8'd111, 8'd110, 8'd109, 8'd107, 8'd106, 8'd105});
        check("f3_windows", 72'(dut_hs), 72'(4));
        check("f3_done_pulses", 72'(done_count - d0), 72'(1));

        // Frame 4: frame_start pulsed mid-frame must be ignored.
        d0 = done_count;
        start_frame();
        send_range(0, 9, 50);
        frame_start_i = 1'b1;
        send(8'd60);
        frame_start_i = 1'b0;
        send_range(11, 15, 50);
        wait_done();
        check("f4_first", first_win, {8'd60, 8'd59, 8'd58, 8'd56, 8'd55, 8'd54, 8'd52, 8'd51, 8'd50});
        check("f4_windows", 72'(dut_hs), 72'(4));
        repeat (3) @(posedge clk);
        #1;
        check("f4_done_pulses", 72'(done_count - d0), 72'(1));
        check("f4_idle", 72'(busy_o), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Front-end scheduler for the Sobel datapath: accepts a raster-order grayscale pixel stream and keeps two line buffers plus a 3x3 shift window.
- Emits one registered sobel_matrix per valid interior pixel position, to drive the combinational Sobel core.
- Sequences each frame with an FSM, applies valid/ready backpressure both ways, and reports frame completion.
- Sits between the grayscale converter output and the Sobel core / output FIFO.

Parameters:
- IMG_WIDTH, 640, pixels per line; must be >= 3.
- IMG_HEIGHT, 480, lines per frame; must be >= 3.
- PIXEL_WIDTH, 8, grayscale pixel width; equals the pixel field width of sobel_matrix.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- nreset_i  in  1  synchronous, active-low reset.
- frame_start_i  in  1  one-cycle pulse; arms a new frame. Honoured only in IDLE.
- pix_data_i  in  PIXEL_WIDTH  input pixel.
- pix_valid_i  in  1  pix_data_i valid.
- pix_ready_o  out  1  controller can accept a pixel this cycle.
- matrix_pixels_o  out  sobel_matrix  3x3 window, registered.
- win_valid_o  out  1  matrix_pixels_o valid.
- win_ready_i  in  1  downstream accepts the window.
- busy_o  out  1  high in any state other than IDLE.
- frame_done_o  out  1  one-cycle pulse when the last window of a frame has been accepted.

Behaviour:
- Reset (nreset_i=0 at a clock edge):
  - FSM to IDLE; row/col counters to 0.
  - win_valid_o, pix_ready_o, busy_o, frame_done_o all 0; matrix_pixels_o all zeros.
  - Line buffer contents are not reset.
  - Reset mid-frame discards the frame; no frame_done_o is issued.
- Pixel acceptance:
  - A pixel is accepted when pix_valid_i && pix_ready_o.
  - pix_ready_o = (state is PRIME or RUN) && (!win_valid_o || win_ready_i).
- Per accepted pixel at (row, col):
  - The column taps are shifted: line1[col] moves to line0[col], pix_data_i is written to line1[col].
  - The 3x3 window shifts one column left, and a new right column {line0[col], line1[col], pix_data_i} enters.
  - col increments and wraps to 0 at IMG_WIDTH-1. On wrap, row increments.
- Window orientation:
  - vector0 = row r-2, vector1 = row r-1, vector2 = row r.
  - pix0 = col c-2, pix1 = col c-1, pix2 = col c.
- Output register:
  - When an accepted pixel has row >= 2 && col >= 2, the next cycle has win_valid_o=1 and the new window on matrix_pixels_o. Latency is 1 clock.
  - Otherwise, win_valid_o clears on win_ready_i.
  - win_valid_o and matrix_pixels_o are held stable while win_valid_o && !win_ready_i.
- Windows per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2). No border windows are emitted, and no zero padding is applied.
- FSM transitions:
  - IDLE -> PRIME on frame_start_i.
  - PRIME (rows 0..1, no outputs) -> RUN when the pixel at (1, IMG_WIDTH-1) is accepted.
  - RUN -> FLUSH when the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted. Counters clear to 0.
  - FLUSH: pix_ready_o=0. When win_valid_o && win_ready_i, or when win_valid_o is already 0: pulse frame_done_o for 1 cycle and go to IDLE.
- Boundary conditions:
  - pix_valid_i in IDLE or FLUSH is ignored, since ready is 0.
  - frame_start_i outside IDLE is ignored.
  - Simultaneous accepted pixel and window handoff in the same cycle: the old window is consumed and the new window loaded, with no bubble.
  - Sustained throughput is 1 pixel/clock when win_ready_i=1.
- Width: col counter is clog2(IMG_WIDTH) bits and row counter is clog2(IMG_HEIGHT) bits; both are unsigned.

Optional Feature:
- Macro SOBEL_WIN_COUNT_EN.
- When defined:
  - Adds output win_count_o, width clog2((IMG_WIDTH-2)*(IMG_HEIGHT-2)+1).
  - The counter increments on each win_valid_o && win_ready_i.
  - It clears on reset and on frame_start_i accepted in IDLE, and holds its final value after frame_done_o.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 streamed with win_ready_i=1 -> 4 windows.
  - First window: vector0={0,1,2}, vector1={4,5,6}, vector2={8,9,10}.
  - Last window: vector0={5,6,7}, vector1={9,10,11}, vector2={13,14,15}.
  - frame_done_o pulses once, one cycle after the last window handshake; FSM returns to IDLE.
- Backpressure: hold win_ready_i=0 for 5 cycles while a window is pending -> pix_ready_o=0; matrix_pixels_o unchanged; no pixel lost; window sequence identical to the unstalled run.
- Pixels with pix_valid_i=1 before frame_start_i -> pix_ready_o=0, busy_o=0, no windows. After frame_start_i, busy_o=1 next cycle.
- Assert nreset_i=0 after pixel 9 of a 4x4 frame -> next cycle all outputs 0 and state IDLE; a fresh frame then yields exactly 4 correct windows.
- frame_start_i pulsed during RUN -> ignored; window count and frame_done_o timing unchanged.
- With SOBEL_WIN_COUNT_EN, 5x4 frame -> win_count_o reaches 6 at frame_done_o and resets to 0 on the next frame_start_i.
